router_reg_param: RTL

Parametrised successor of the router 1x3 input register stage. It sits between the input interface and the per-channel FIFOs, and is driven by the router FSM state strobes. It does four things:
- latches the header and forwards header/payload/parity to the FIFO data bus;
- holds one word while the FIFO is full;
- computes running XOR parity, flagging a mismatch with the packet's parity word;
- adds a payload-length check against the header length field and a saturating error counter.

---
 rtl/router_pkg.sv | 15 +
 rtl/router_sat_counter.sv | 19 +
 rtl/router_reg_param.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants and helpers for the router input-register stage.
package router_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 2;

  // All-ones address marks an unroutable header; truncate to the address width at use.
  localparam logic [31:0] INVALID_ADDR = '1;

  // Width of the header length field, which sits above the address field.
  function automatic int unsigned len_width(input int unsigned dw, input int unsigned aw);
    return dw - aw;
  endfunction

endpackage

// File: rtl/router_sat_counter.sv
// Generic saturating up-counter with synchronous enable and asynchronous reset.
module router_sat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/router_reg_param.sv
// Router input register stage: header latch, full-FIFO hold, running parity,
// payload length check and saturating error count.
module router_reg_param
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter bit          LEN_CHECK     = 1'b1,
  parameter int unsigned ERR_CNT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pkt_valid,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     fifo_full,
  input  logic                     rst_int_reg,
  input  logic                     detect_add,
  input  logic                     ld_state,
  input  logic                     laf_state,
  input  logic                     full_state,
  input  logic                     lfd_state,
  output logic                     parity_done,
  output logic                     low_pkt_valid,
  output logic                     err,
  output logic                     len_err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [DATA_WIDTH-1:0]    dout
);

  localparam int unsigned LEN_WIDTH = len_width(DATA_WIDTH, ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] header_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [DATA_WIDTH-1:0] int_parity;
  logic [DATA_WIDTH-1:0] pkt_parity;
  logic [LEN_WIDTH-1:0]  pay_cnt;
  logic                  check_pend;
  logic                  parity_done_q;

  logic hdr_ok;
  logic pay_take;
  logic pd_from_ld;
  logic pd_from_laf;
  logic err_new;
  logic len_new;
  logic cnt_en;

  assign hdr_ok      = detect_add & pkt_valid &
                       (data_in[ADDR_WIDTH-1:0] != ADDR_WIDTH'(INVALID_ADDR));
  assign pay_take    = ld_state & pkt_valid & ~full_state;
  assign pd_from_ld  = ld_state & ~fifo_full & ~pkt_valid;
  assign pd_from_laf = laf_state & low_pkt_valid & ~parity_done;
  assign err_new     = (int_parity != pkt_parity);
  assign len_new     = LEN_CHECK && (pay_cnt != header_reg[DATA_WIDTH-1:ADDR_WIDTH]);
  // A fresh header in the check cycle discards the old packet's verdict.
  assign cnt_en      = check_pend & ~detect_add & (err_new | len_new);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      header_reg <= '0;
    end else if (hdr_ok) begin
      header_reg <= data_in;
    end
  end

  // FIFO data path; the hold register parks a word the full FIFO could not take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= '0;
      hold_reg <= '0;
    end else if (lfd_state) begin
      dout <= header_reg;
    end else if (ld_state && !fifo_full) begin
      dout <= data_in;
    end else if (ld_state && fifo_full) begin
      hold_reg <= data_in;
    end else if (laf_state) begin
      dout <= hold_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_pkt_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
    end
  end

  // Parity word capture, either straight off the bus or from the hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_done <= 1'b0;
      pkt_parity  <= '0;
    end else if (pd_from_ld) begin
      parity_done <= 1'b1;
      pkt_parity  <= data_in;
    end else if (pd_from_laf) begin
      parity_done <= 1'b1;
      pkt_parity  <= hold_reg;
    end else if (detect_add) begin
      parity_done <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_parity <= '0;
      pay_cnt    <= '0;
    end else if (detect_add) begin
      int_parity <= '0;
      pay_cnt    <= '0;
    end else if (lfd_state) begin
      int_parity <= int_parity ^ header_reg;
    end else if (pay_take) begin
      int_parity <= int_parity ^ data_in;
      pay_cnt    <= pay_cnt + LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_done_q <= 1'b0;
      check_pend    <= 1'b0;
    end else begin
      parity_done_q <= parity_done;
      check_pend    <= parity_done & ~parity_done_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      len_err <= 1'b0;
    end else if (detect_add) begin
      err     <= 1'b0;
      len_err <= 1'b0;
    end else if (check_pend) begin
      err     <= err_new;
      len_err <= len_new;
    end
  end

  router_sat_counter #(
    .WIDTH (ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .count (err_cnt)
  );

endmodule
